// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, default tap value and loader FSM states for the FIR coefficient path.
package fir_pkg;
  localparam int COEF_W = 25;
  localparam int FIR_MAX_LEN = 32;
  localparam logic [COEF_W-1:0] DEFAULT_COEF = 25'h80;
  typedef logic [COEF_W-1:0] coef_t;
  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;
endpackage

// File: rtl/coef_stage_ram.sv
// coef_stage_ram: coefficient staging store with one write port, two registered read ports
// and a bulk fill to the default value on reset or init.
module coef_stage_ram #(
  parameter int DEPTH = 32,
  parameter int ADDR_W = 5,
  parameter int COEF_W = 25,
  parameter logic [COEF_W-1:0] INIT = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [COEF_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [COEF_W-1:0] ra_data,
  input  logic              rb_en,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [COEF_W-1:0] rb_data
);
  logic [COEF_W-1:0] mem [DEPTH];
  logic wr_hit;
  assign wr_hit = we && int'(waddr) < DEPTH;
  // Reads see a same-cycle write or fill, so readback is write-first.
  function automatic logic [COEF_W-1:0] peek(input logic [ADDR_W-1:0] a);
    return init ? INIT : (wr_hit && waddr == a) ? wdata : mem[a];
  endfunction
  always_ff @(posedge clk) begin
    if (!reset_n || init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT;
    end else if (wr_hit) begin
      mem[waddr] <= wdata;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ra_data <= '0;
      rb_data <= '0;
    end else begin
      ra_data <= peek(ra_addr);
      if (rb_en) rb_data <= peek(rb_addr);
    end
  end
endmodule

// File: rtl/fir_coef_loader.sv
// fir_coef_loader: stages CPU-written taps and streams them last-first into the filter
// coefficient chain so that staged tap k lands in filter tap k+1.
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int MAX_LEN = FIR_MAX_LEN,
  parameter int ADDR_W = $clog2(MAX_LEN),
  parameter int COEF_W = fir_pkg::COEF_W,
  parameter int CE_GAP = 0,
  parameter logic [COEF_W-1:0] DEFAULT_COEF = fir_pkg::DEFAULT_COEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  input  logic              load_default,
  input  logic              commit,
  input  logic [31:0]       fir_len,
  output logic [COEF_W-1:0] cfg_din,
  output logic              cfg_ce,
  output logic              busy,
  output logic              done,
  output logic              err_len,
  output logic              wr_drop
);
  localparam int GAP_W = CE_GAP > 0 ? $clog2(CE_GAP + 1) : 1;
  state_t state, next_state;
  logic [31:0] n;
  logic [ADDR_W-1:0] idx, rb_addr;
  logic [GAP_W-1:0] gap;
  logic [COEF_W-1:0] ra_data;
  logic bad, wr_ok, emit, rb_en;
  assign bad = n == 32'd0 || n > 32'(MAX_LEN);
  // A rejected commit never touches the store, so CPU access stays open during that CHECK.
  assign wr_ok = state == IDLE || state == DONE || (state == CHECK && bad);
  assign emit = state == SHIFT && gap == '0;
  assign rb_en = (state == CHECK && !bad) || (emit && idx != '0);
  assign rb_addr = state == CHECK ? n[ADDR_W-1:0] - ADDR_W'(1) : idx - ADDR_W'(1);
  coef_stage_ram #(
    .DEPTH(MAX_LEN),
    .ADDR_W(ADDR_W),
    .COEF_W(COEF_W),
    .INIT(DEFAULT_COEF)
  ) u_ram (
    .clk(clk),
    .reset_n(reset_n),
    .init(load_default && wr_ok),
    .we(wr_en && wr_ok && !load_default),
    .waddr(wr_addr),
    .wdata(wr_data[COEF_W-1:0]),
    .ra_addr(rd_addr),
    .ra_data(ra_data),
    .rb_en(rb_en),
    .rb_addr(rb_addr),
    .rb_data(cfg_din)
  );
  assign rd_data = {{(32-COEF_W){ra_data[COEF_W-1]}}, ra_data};
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else state <= next_state;
  end
  always_comb begin
    next_state = state == IDLE  ? (commit ? CHECK : IDLE)
               : state == CHECK ? (bad ? IDLE : SHIFT)
               : state == SHIFT ? ((emit && idx == '0) ? DONE : SHIFT)
               : IDLE;
  end
  always_comb begin
    cfg_ce = emit;
    busy = state == CHECK || state == SHIFT;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      n <= '0;
      idx <= '0;
      gap <= '0;
      err_len <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      if (state == IDLE && commit) begin
        n <= fir_len;
        err_len <= 1'b0;
      end
      if (state == CHECK) begin
        idx <= n[ADDR_W-1:0] - ADDR_W'(1);
        gap <= '0;
        err_len <= bad;
      end
      if (emit) begin
        idx <= idx - ADDR_W'(1);
        gap <= GAP_W'(CE_GAP);
      end else if (state == SHIFT) begin
        gap <= gap - GAP_W'(1);
      end
      wr_drop <= (state == IDLE && commit) ? 1'b0 : wr_drop | ((wr_en | load_default) & ~wr_ok);
    end
  end
endmodule

// File: tb/tb_fir_coef_loader.sv
// tb_fir_coef_loader: scoreboard bench; commits push expected cfg_din values, a monitor pops
// them on every cfg_ce and also shifts a model filter chain.
module tb_fir_coef_loader;
  logic clk = 1'b0, reset_n = 1'b0;
  logic wr_en [2], load_default [2], commit [2];
  logic [4:0] wr_addr [2], rd_addr [2];
  logic [31:0] wr_data [2], fir_len [2], rd_data [2];
  logic [24:0] cfg_din [2];
  logic cfg_ce [2], busy [2], done [2], err_len [2], wr_drop [2];
  logic [24:0] stage [2][32];
  logic [24:0] chain [2][1:32];
  logic [24:0] exp_q0 [$], exp_q1 [$];
  int ce_cyc0 [$], ce_cyc1 [$];
  int tests = 0, fails = 0, cyc = 0, t0;
  logic [31:0] v;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_coef_loader #(.CE_GAP(0)) u0 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .load_default(load_default[0]), .commit(commit[0]),
    .fir_len(fir_len[0]), .cfg_din(cfg_din[0]), .cfg_ce(cfg_ce[0]), .busy(busy[0]), .done(done[0]),
    .err_len(err_len[0]), .wr_drop(wr_drop[0])
  );
  fir_coef_loader #(.CE_GAP(2)) u1 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .load_default(load_default[1]), .commit(commit[1]),
    .fir_len(fir_len[1]), .cfg_din(cfg_din[1]), .cfg_ce(cfg_ce[1]), .busy(busy[1]), .done(done[1]),
    .err_len(err_len[1]), .wr_drop(wr_drop[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cfg_ce pops one expected coefficient and shifts the model chain.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (cfg_ce[d] === 1'b1) begin
        logic [24:0] e;
        bit ok;
        e = '0;
        ok = 1'b0;
        if (d == 0) begin
          ok = exp_q0.size() > 0;
          if (ok) e = exp_q0.pop_front();
          ce_cyc0.push_back(cyc);
        end else begin
          ok = exp_q1.size() > 0;
          if (ok) e = exp_q1.pop_front();
          ce_cyc1.push_back(cyc);
        end
        if (!ok) begin
          tests++;
          fails++;
          $display("FAIL unexpected_cfg_ce dut%0d: got cfg_din %h expected no pulse", d, cfg_din[d]);
        end else begin
          check($sformatf("cfg_din_dut%0d", d), 32'(cfg_din[d]), 32'(e));
        end
        for (int k = 32; k > 1; k--) chain[d][k] = chain[d][k-1];
        chain[d][1] = cfg_din[d];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int d, input int a, input logic [31:0] val);
    wr_en[d] = 1'b1;
    wr_addr[d] = 5'(a);
    wr_data[d] = val;
    tick();
    wr_en[d] = 1'b0;
    stage[d][a] = val[24:0];
  endtask

  task automatic rd(input int d, input int a, output logic [31:0] val);
    rd_addr[d] = 5'(a);
    tick();
    val = rd_data[d];
  endtask

  task automatic run(input int d, input int len, input int gap, input bit mid, output int t);
    fir_len[d] = 32'(len);
    commit[d] = 1'b1;
    t = cyc;
    for (int i = len - 1; i >= 0; i--) begin
      if (d == 0) exp_q0.push_back(stage[d][i]);
      else exp_q1.push_back(stage[d][i]);
    end
    tick();
    commit[d] = 1'b0;
    check("busy_after_commit", 32'(busy[d]), 1);
    for (int i = 0; i < 300 && done[d] !== 1'b1; i++) begin
      wr_en[d] = mid && cyc == t + 4;
      wr_addr[d] = 5'd0;
      wr_data[d] = 32'h555;
      tick();
    end
    wr_en[d] = 1'b0;
    check("done_seen", 32'(done[d]), 1);
    check("done_cycle", 32'(cyc), 32'(t + 2 + (gap + 1) * (len - 1) + 1));
    check("busy_at_done", 32'(busy[d]), 0);
    tick();
    check("done_one_cycle", 32'(done[d]), 0);
    check("queue_drained", 32'(d == 0 ? exp_q0.size() : exp_q1.size()), 0);
  endtask

  task automatic bad_commit(input int d, input int len);
    fir_len[d] = 32'(len);
    commit[d] = 1'b1;
    tick();
    commit[d] = 1'b0;
    check("busy_in_check", 32'(busy[d]), 1);
    tick();
    check("busy_after_reject", 32'(busy[d]), 0);
    check("err_len_set", 32'(err_len[d]), 1);
    check("no_done_reject", 32'(done[d]), 0);
    tick();
    check("no_done_reject2", 32'(done[d]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      wr_en[d] = 0; load_default[d] = 0; commit[d] = 0;
      wr_addr[d] = 0; rd_addr[d] = 0; wr_data[d] = 0; fir_len[d] = 32;
      for (int i = 0; i < 32; i++) stage[d][i] = 25'h80;
      for (int k = 1; k <= 32; k++) chain[d][k] = '0;
    end
    repeat (3) tick();
    reset_n = 1'b1;
    check("rst_cfg_ce", 32'(cfg_ce[0]), 0);
    check("rst_cfg_din", 32'(cfg_din[0]), 0);
    check("rst_busy", 32'(busy[0]), 0);
    check("rst_done", 32'(done[0]), 0);
    check("rst_err_len", 32'(err_len[0]), 0);
    check("rst_wr_drop", 32'(wr_drop[0]), 0);
    check("rst_rd_data", rd_data[0], 0);

    // Default taps streamed back-to-back.
    ce_cyc0.delete();
    run(0, 32, 0, 0, t0);
    check("first_ce_cycle", 32'(ce_cyc0.size() > 0 ? ce_cyc0[0] : -1), 32'(t0 + 2));
    check("last_ce_cycle", 32'(ce_cyc0.size() == 32 ? ce_cyc0[31] : -1), 32'(t0 + 33));
    check("chain_default_1", 32'(chain[0][1]), 32'h80);
    check("chain_default_32", 32'(chain[0][32]), 32'h80);

    // Ramp: filter tap k must end holding k.
    for (int i = 0; i < 32; i++) write(0, i, 32'(i + 1));
    run(0, 32, 0, 0, t0);
    for (int k = 1; k <= 32; k++) check($sformatf("chain_tap%0d", k), 32'(chain[0][k]), 32'(k));
    rd(0, 5, v);
    check("rd_addr5", v, 32'd6);

    // Length errors, then a valid commit clears the flag.
    bad_commit(0, 0);
    bad_commit(0, 33);
    run(0, 4, 0, 0, t0);
    check("err_len_cleared", 32'(err_len[0]), 0);

    // Sign extension and upper-bit discard.
    write(0, 3, 32'h01FF_FFFF);
    rd(0, 3, v);
    check("rd_sext", v, 32'hFFFF_FFFF);
    write(0, 3, 32'hFE00_0001);
    rd(0, 3, v);
    check("rd_upper_ignored", v, 32'd1);

    // load_default beats a simultaneous write.
    load_default[0] = 1'b1;
    wr_en[0] = 1'b1;
    wr_addr[0] = 5'd7;
    wr_data[0] = 32'h33;
    tick();
    load_default[0] = 1'b0;
    wr_en[0] = 1'b0;
    for (int i = 0; i < 32; i++) stage[0][i] = 25'h80;
    rd(0, 7, v);
    check("load_default_wins", v, 32'h80);

    // CE_GAP=2 spacing and a dropped mid-stream write.
    for (int i = 0; i < 4; i++) write(1, i, 32'(32'h100 + i));
    ce_cyc1.delete();
    run(1, 4, 2, 1, t0);
    for (int j = 0; j < 4; j++)
      check($sformatf("gap_ce%0d_cycle", j), 32'(ce_cyc1.size() == 4 ? ce_cyc1[j] : -1), 32'(t0 + 2 + 3 * j));
    check("wr_drop_set", 32'(wr_drop[1]), 1);
    for (int k = 1; k <= 4; k++) check($sformatf("gap_chain%0d", k), 32'(chain[1][k]), 32'(32'h100 + k - 1));
    rd(1, 0, v);
    check("drop_left_staging", v, 32'h100);

    // Reset during the 10th pulse aborts the stream and refills the store.
    for (int i = 0; i < 32; i++) write(0, i, 32'(32'h200 + i));
    fir_len[0] = 32;
    commit[0] = 1'b1;
    t0 = cyc;
    for (int i = 31; i >= 0; i--) exp_q0.push_back(stage[0][i]);
    tick();
    commit[0] = 1'b0;
    for (int i = 0; i < 50 && cyc < t0 + 11; i++) tick();
    check("ce_at_abort", 32'(cfg_ce[0]), 1);
    reset_n = 1'b0;
    tick();
    check("abort_cfg_ce", 32'(cfg_ce[0]), 0);
    check("abort_busy", 32'(busy[0]), 0);
    check("abort_remaining", 32'(exp_q0.size()), 22);
    exp_q0.delete();
    reset_n = 1'b1;
    for (int d = 0; d < 2; d++) for (int i = 0; i < 32; i++) stage[d][i] = 25'h80;
    rd(0, 31, v);
    check("abort_staging_default", v, 32'h80);
    run(0, 32, 0, 0, t0);
    check("recommit_chain_32", 32'(chain[0][32]), 32'h80);
    check("recommit_chain_1", 32'(chain[0][1]), 32'h80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
